// File: rtl/spmv_mem_responder.sv
// spmv_mem_responder: single-port 64-bit word RAM answering tagged loads
// through a fixed-latency pipeline and an in-order response FIFO, with
// registered credit-based backpressure toward the requester.
// Optional build macro SPMV_MEM_RESPONDER_STATS_EN adds saturating
// ld_count / st_count outputs.
module spmv_mem_responder #(
  parameter int DEPTH_LOG2 = 13,
  parameter int LATENCY    = 4,
  parameter int FIFO_LOG2  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_mem_ld,
  input  logic        req_mem_st,
  input  logic [47:0] req_mem_addr,
  input  logic [63:0] req_mem_d_or_tag,
  output logic        req_mem_stall,
  output logic        rsp_mem_push,
  output logic [2:0]  rsp_mem_tag,
  output logic [63:0] rsp_mem_q,
  input  logic        rsp_mem_stall,
  output logic        err
`ifdef SPMV_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0] ld_count,
  output logic [31:0] st_count
`endif
);

  // Credit counter is wide enough for FIFO depth plus the one slack load.
  localparam int CW = FIFO_LOG2 + 2;
  localparam logic [CW-1:0] STALL_TH = CW'((1 << FIFO_LOG2) - 1);

  typedef struct packed {
    logic [2:0]  tag;
    logic [63:0] q;
  } rsp_t;

  logic [63:0]           mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  oor;
  logic                  addr_unused;
  logic                  ld_drop;
  logic                  ld_acc;
  logic                  st_do;
  logic                  err_set;
  logic                  stall_d;
  logic [LATENCY:1]      vld_pipe;
  rsp_t                  ent_pipe [1:LATENCY];
  rsp_t                  fifo [2**FIFO_LOG2];
  rsp_t                  head;
  logic [FIFO_LOG2:0]    wp, rp;
  logic                  pop;
  logic [CW-1:0]         cnt, cnt_nxt;

  assign idx         = req_mem_addr[DEPTH_LOG2+2:3];
  assign oor         = |req_mem_addr[47:DEPTH_LOG2+3];
  assign addr_unused = ^req_mem_addr[2:0];

  // A load is dropped only once stall has been visible for a full cycle;
  // the first stalled cycle is the slack the credit threshold reserves.
  assign ld_drop = req_mem_ld && !req_mem_st && req_mem_stall && stall_d;
  assign ld_acc  = !rst && req_mem_ld && !req_mem_st && !ld_drop;
  assign st_do   = !rst && req_mem_st && !oor;
  assign err_set = !rst && (((req_mem_ld || req_mem_st) && oor) ||
                            (req_mem_ld && req_mem_st) || ld_drop);

  // Response side: push whenever the FIFO holds data and the consumer is ready.
  assign head         = fifo[rp[FIFO_LOG2-1:0]];
  assign pop          = !rst && (wp != rp) && !rsp_mem_stall;
  assign rsp_mem_push = pop;
  assign rsp_mem_tag  = pop ? head.tag : 3'd0;
  assign rsp_mem_q    = pop ? head.q : 64'd0;

  // Store write port; RAM is deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (st_do) mem[idx] <= req_mem_d_or_tag;
  end

  // Load pipeline payload: RAM read at the request edge, then shifted.
  always_ff @(posedge clk) begin
    ent_pipe[1].tag <= req_mem_d_or_tag[2:0];
    ent_pipe[1].q   <= oor ? 64'd0 : mem[idx];
    for (int s = 2; s <= LATENCY; s++) ent_pipe[s] <= ent_pipe[s-1];
  end

  // Load pipeline valid shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= ld_acc;
      for (int s = 2; s <= LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  // Response FIFO: written from the last pipeline stage, read on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (vld_pipe[LATENCY]) begin
        fifo[wp[FIFO_LOG2-1:0]] <= ent_pipe[LATENCY];
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end

  // Next credit count: loads entering minus responses leaving.
  always_comb begin
    cnt_nxt = cnt;
    if (ld_acc && !pop)      cnt_nxt = cnt + CW'(1);
    else if (!ld_acc && pop) cnt_nxt = cnt - CW'(1);
  end

  // Credit count and registered backpressure with one-cycle history.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      req_mem_stall <= 1'b0;
      stall_d       <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      req_mem_stall <= (cnt_nxt >= STALL_TH);
      stall_d       <= req_mem_stall;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

`ifdef SPMV_MEM_RESPONDER_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_count <= '0;
      st_count <= '0;
    end else begin
      if (ld_acc && ld_count != 32'hFFFF_FFFF) ld_count <= ld_count + 32'd1;
      if (st_do && st_count != 32'hFFFF_FFFF)  st_count <= st_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spmv_mem_responder.sv
// Self-checking bench for spmv_mem_responder: table of store/load vectors
// plus hand-written sequences for latency, backpressure, range errors,
// ld+st collisions, reset and consumer-stall toggling. Expected responses
// go into a scoreboard queue when the load is driven.
module tb_spmv_mem_responder;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_mem_ld = 1'b0;
  logic        req_mem_st = 1'b0;
  logic [47:0] req_mem_addr = '0;
  logic [63:0] req_mem_d_or_tag = '0;
  logic        req_mem_stall;
  logic        rsp_mem_push;
  logic [2:0]  rsp_mem_tag;
  logic [63:0] rsp_mem_q;
  logic        rsp_mem_stall = 1'b0;
  logic        err;

  spmv_mem_responder #(.DEPTH_LOG2(13), .LATENCY(LAT), .FIFO_LOG2(3)) dut (
    .clk(clk), .rst(rst),
    .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st),
    .req_mem_addr(req_mem_addr), .req_mem_d_or_tag(req_mem_d_or_tag),
    .req_mem_stall(req_mem_stall),
    .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
    .rsp_mem_stall(rsp_mem_stall), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  tag;
    logic [63:0] q;
  } exp_t;

  typedef struct {
    bit          is_st;
    logic [47:0] addr;
    logic [63:0] d_tag;
    logic [63:0] exp_q;
  } vec_t;

  exp_t sbq[$];
  int   nerr = 0;
  int   nchk = 0;
  int   npush = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Response monitor: every push is matched against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_mem_push === 1'b1) begin
      npush++;
      chk("push_under_stall", 64'(rsp_mem_stall), 64'd0);
      if (sbq.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_push: tag=%0d q=%h, no response was due", rsp_mem_tag, rsp_mem_q);
      end else begin
        e = sbq.pop_front();
        chk("rsp_tag", 64'(rsp_mem_tag), 64'(e.tag));
        chk("rsp_q", rsp_mem_q, e.q);
      end
    end else begin
      chk("idle_tag", 64'(rsp_mem_tag), 64'd0);
      chk("idle_q", rsp_mem_q, 64'd0);
    end
  end

  task automatic do_st(input logic [47:0] a, input logic [63:0] d);
    req_mem_st = 1'b1; req_mem_addr = a; req_mem_d_or_tag = d;
    @(posedge clk); #1;
    req_mem_st = 1'b0;
  endtask

  task automatic do_ld(input logic [47:0] a, input logic [2:0] t,
                       input logic [63:0] q, input bit expect_rsp);
    exp_t e;
    req_mem_ld = 1'b1; req_mem_addr = a; req_mem_d_or_tag = 64'(t);
    if (expect_rsp) begin
      e.tag = t; e.q = q;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    req_mem_ld = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; req_mem_ld = 1'b0; req_mem_st = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vt[9];

  initial begin
    int k;
    int np0;
    int issued;
    int cyc;
    exp_t e;

    vt[0] = '{1'b1, 48'h48,   64'hDEADBEEF01234567, 64'h0};
    vt[1] = '{1'b0, 48'h48,   64'd1,                64'hDEADBEEF01234567};
    vt[2] = '{1'b1, 48'h4F,   64'hA5A5A5A5A5A5A5A5, 64'h0};
    vt[3] = '{1'b0, 48'h48,   64'd2,                64'hA5A5A5A5A5A5A5A5};
    vt[4] = '{1'b1, 48'h0,    64'h1111,             64'h0};
    vt[5] = '{1'b0, 48'h7,    64'd3,                64'h1111};
    vt[6] = '{1'b1, 48'hFFF8, 64'hCAFE,             64'h0};
    vt[7] = '{1'b0, 48'hFFF8, 64'd4,                64'hCAFE};
    vt[8] = '{1'b0, 48'h40,   64'd5,                64'h3FF0000000000000};

    // Reset state
    do_reset(3);
    chk("rst_push", 64'(rsp_mem_push), 64'd0);
    chk("rst_tag", 64'(rsp_mem_tag), 64'd0);
    chk("rst_q", rsp_mem_q, 64'd0);
    chk("rst_stall", 64'(req_mem_stall), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // Store then next-cycle load to the same word; measure push latency
    do_st(48'h40, 64'h3FF0000000000000);
    req_mem_ld = 1'b1; req_mem_addr = 48'h40; req_mem_d_or_tag = 64'd5;
    e.tag = 3'd5; e.q = 64'h3FF0000000000000;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_mem_ld = 1'b0;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rsp_mem_push === 1'b1) begin k = c; break; end
    end
    chk("push_latency", 64'(k), 64'(LAT + 1));
    idle(3);

    // Table-driven store/load vectors
    for (int i = 0; i < 9; i++) begin
      if (vt[i].is_st) do_st(vt[i].addr, vt[i].d_tag);
      else             do_ld(vt[i].addr, vt[i].d_tag[2:0], vt[i].exp_q, 1'b1);
    end
    idle(12);
    chk("table_drained", 64'(sbq.size()), 64'd0);
    chk("table_err", 64'(err), 64'd0);

    // Fill the FIFO with the consumer stalled; check slack and drop
    for (int i = 0; i < 8; i++) do_st(48'h80 + 48'(8 * i), 64'h1000 + 64'(i));
    rsp_mem_stall = 1'b1;
    np0 = npush;
    for (int i = 0; i < 9; i++) begin
      chk("fill_stall", 64'(req_mem_stall), (i >= 7) ? 64'd1 : 64'd0);
      if (i == 8) chk("err_before_drop", 64'(err), 64'd0);
      if (i < 8) do_ld(48'h80 + 48'(8 * i), 3'(i), 64'h1000 + 64'(i), 1'b1);
      else       do_ld(48'h80, 3'd0, 64'h0, 1'b0);
    end
    chk("err_after_drop", 64'(err), 64'd1);
    idle(10);
    chk("held_no_push", 64'(npush - np0), 64'd0);
    rsp_mem_stall = 1'b0;
    idle(15);
    chk("fill_pushes", 64'(npush - np0), 64'd8);
    chk("fill_drained", 64'(sbq.size()), 64'd0);
    chk("fill_stall_clear", 64'(req_mem_stall), 64'd0);

    // Out-of-range loads and a discarded store
    do_reset(2);
    chk("oor_err_clear", 64'(err), 64'd0);
    do_ld(48'h100000, 3'd6, 64'h0, 1'b1);
    chk("oor_err_set", 64'(err), 64'd1);
    do_ld(48'h10000, 3'd7, 64'h0, 1'b1);
    do_st(48'h100000, 64'hFFFF);
    do_ld(48'h0, 3'd2, 64'h1111, 1'b1);
    idle(10);
    chk("oor_drained", 64'(sbq.size()), 64'd0);

    // Load and store together: store only, error, no response
    do_reset(1);
    np0 = npush;
    req_mem_ld = 1'b1; req_mem_st = 1'b1; req_mem_addr = 48'h8; req_mem_d_or_tag = 64'd7;
    @(posedge clk); #1;
    req_mem_ld = 1'b0; req_mem_st = 1'b0;
    chk("ldst_err", 64'(err), 64'd1);
    idle(8);
    chk("ldst_no_push", 64'(npush - np0), 64'd0);
    do_ld(48'h8, 3'd1, 64'd7, 1'b1);
    idle(8);
    chk("ldst_drained", 64'(sbq.size()), 64'd0);

    // Reset with loads in flight: discarded, RAM kept
    np0 = npush;
    for (int i = 0; i < 3; i++) do_ld(48'h8, 3'(i), 64'h0, 1'b0);
    do_reset(1);
    chk("inflt_stall", 64'(req_mem_stall), 64'd0);
    chk("inflt_err", 64'(err), 64'd0);
    chk("inflt_push", 64'(rsp_mem_push), 64'd0);
    idle(10);
    chk("inflt_no_push", 64'(npush - np0), 64'd0);
    do_ld(48'h8, 3'd3, 64'd7, 1'b1);
    idle(8);

    // Consumer stall toggling every cycle during 16 loads
    np0 = npush;
    issued = 0;
    cyc = 0;
    while ((issued < 16 || sbq.size() != 0) && cyc < 300) begin
      rsp_mem_stall = ~rsp_mem_stall;
      if (issued < 16 && !req_mem_stall) begin
        req_mem_ld = 1'b1;
        req_mem_addr = 48'h80 + 48'(8 * (issued % 8));
        req_mem_d_or_tag = 64'(issued % 8);
        e.tag = 3'(issued % 8); e.q = 64'h1000 + 64'(issued % 8);
        sbq.push_back(e);
        issued++;
      end else begin
        req_mem_ld = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_mem_ld = 1'b0;
    rsp_mem_stall = 1'b0;
    idle(4);
    chk("toggle_issued", 64'(issued), 64'd16);
    chk("toggle_pushes", 64'(npush - np0), 64'd16);
    chk("toggle_drained", 64'(sbq.size()), 64'd0);
    chk("toggle_err", 64'(err), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
